// File: rtl/param_load_counter_if.sv
// rtl/param_load_counter_if.sv - control and status bundle for param_load_counter
interface param_load_counter_if #(
    parameter int WIDTH = 10
);
    logic             load_en;
    logic [WIDTH-1:0] data_in;
    logic             cnt_en;
    logic             up_dn;
    logic             limit_wr;
    logic [WIDTH-1:0] limit_in;
    logic             clr_flags;
    logic [WIDTH-1:0] count_out;
    logic             tc;
    logic             wrap_flag;

    modport master (
        output load_en, data_in, cnt_en, up_dn, limit_wr, limit_in, clr_flags,
        input  count_out, tc, wrap_flag
    );

    modport slave (
        input  load_en, data_in, cnt_en, up_dn, limit_wr, limit_in, clr_flags,
        output count_out, tc, wrap_flag
    );
endinterface

// File: rtl/param_load_counter.sv
// rtl/param_load_counter.sv - loadable up/down counter with limit register, step and wrap/saturate
module param_load_counter #(
    parameter int              WIDTH     = 10,
    parameter int unsigned     STEP      = 1,
    parameter bit              SATURATE  = 1'b0,
    parameter logic [WIDTH-1:0] RESET_VAL = '0,
    parameter logic [WIDTH-1:0] LIMIT_RST = '1
) (
    input  logic                 clk,
    input  logic                 reset,
    param_load_counter_if.slave  bus
);
    localparam logic [WIDTH-1:0] STEP_N = STEP[WIDTH-1:0];
    localparam logic [WIDTH:0]   STEP_W = {1'b0, STEP_N};

    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] limit_q;
    logic             tc_q;
    logic             wrap_q;

    logic [WIDTH-1:0] count_d;
    logic             boundary;
    logic [WIDTH:0]   sum_w;
    logic [WIDTH:0]   limit_w;
    logic [WIDTH:0]   count_w;

    // Compare in WIDTH+1 bits so an up step past all-ones is still seen as exceeding the limit.
    always_comb begin
        count_d  = count_q;
        boundary = 1'b0;
        count_w  = {1'b0, count_q};
        limit_w  = {1'b0, limit_q};
        sum_w    = count_w + STEP_W;
        if (bus.load_en) begin
            count_d = bus.data_in;
        end else if (bus.cnt_en) begin
            if (bus.up_dn) begin
                if (sum_w > limit_w) begin
                    boundary = 1'b1;
                    count_d  = SATURATE ? limit_q : '0;
                end else begin
                    count_d = sum_w[WIDTH-1:0];
                end
            end else begin
                if (count_w >= STEP_W) begin
                    count_d = count_q - STEP_N;
                end else begin
                    boundary = 1'b1;
                    count_d  = SATURATE ? '0 : limit_q;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            count_q <= RESET_VAL;
            limit_q <= LIMIT_RST;
            tc_q    <= 1'b0;
            wrap_q  <= 1'b0;
        end else begin
            count_q <= count_d;
            tc_q    <= boundary;
            // A boundary event in the same cycle as clr_flags leaves the flag set.
            wrap_q  <= boundary | (wrap_q & ~bus.clr_flags);
            if (bus.limit_wr) begin
                limit_q <= bus.limit_in;
            end
        end
    end

    assign bus.count_out = count_q;
    assign bus.tc        = tc_q;
    assign bus.wrap_flag = wrap_q;
endmodule

// File: doc/param_load_counter.md
# param_load_counter

Parametrised successor to the 10-bit loadable counter: a WIDTH-bit loadable up/down counter with a programmable limit register, configurable step, and wrap or saturate behaviour at the boundaries. It reports boundary events on a one-cycle terminal-count pulse and a sticky wrap flag. It sits behind the VPI stimulus flow as the DUT for the next round of `$stimulus_in` regressions, and can be dropped in as a general event/timeout counter.

## Interface

- WIDTH, 10: counter, data and limit width in bits (2..32).
- STEP, 1: increment/decrement per enabled cycle; 1 <= STEP <= 2**WIDTH-1.
- SATURATE, 0: 0 = wrap at boundaries, 1 = clamp at boundaries.
- RESET_VAL, 0: count_out value after reset.
- LIMIT_RST, 2**WIDTH-1: limit register value after reset.

- clk  in  1  single clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high; sampled on rising edge of clk.
- load_en  in  1  load data_in into the counter.
- data_in  in  WIDTH  load value.
- cnt_en  in  1  count one STEP this cycle.
- up_dn  in  1  count direction: 1 = up, 0 = down.
- limit_wr  in  1  write limit_in into the limit register.
- limit_in  in  WIDTH  new upper boundary.
- clr_flags  in  1  clear wrap_flag.
- count_out  out  WIDTH  registered counter value.
- tc  out  1  registered one-cycle pulse on a boundary event.
- wrap_flag  out  1  sticky; set on any wrap or clamp event.

## Operation

- Reset values: count_out = RESET_VAL, limit = LIMIT_RST, tc = 0, wrap_flag = 0. Reset overrides every other input in the same cycle.
- Priority per cycle: reset > load_en > cnt_en. load_en with cnt_en: the load wins, no count occurs, and tc = 0.
- Arithmetic is computed in WIDTH+1 bits. No intermediate value is truncated before comparison.
- Up count (cnt_en=1, up_dn=1), where sum = count_out + STEP:
  - sum <= limit: next = sum.
  - sum > limit: boundary event. Next = 0 (SATURATE=0) or limit (SATURATE=1).
- Down count (cnt_en=1, up_dn=0):
  - count_out >= STEP: next = count_out - STEP.
  - otherwise: boundary event. Next = limit (SATURATE=0) or 0 (SATURATE=1).
- Saturate mode still counts as a boundary event when already sitting at the boundary. Counting up at limit holds limit and pulses tc every enabled cycle.
- A load value above limit is accepted as-is. The next up count is then a boundary event. The next down count is normal decrement arithmetic if count_out >= STEP.
- Limit register:
  - limit_wr updates it at the clock edge.
  - A count step in the same cycle uses the old limit.
  - The current count_out is not modified by a limit write.
- wrap_flag:
  - Set on every boundary event.
  - Cleared by clr_flags.
  - Set wins over clear in the same cycle.
  - Cleared only by reset or clr_flags.
- cnt_en=0 and load_en=0: count_out holds and tc = 0.

## Timing

- Load latency is 1 cycle: data_in sampled at edge N appears on count_out after edge N.
- Count latency is 1 cycle per step; no pipeline. Sustains one step per clock.
- tc is registered and high for exactly the cycle in which count_out shows the post-event value.
- wrap_flag rises in that same cycle.
- All outputs are registered; there is no combinational path from inputs to outputs.
- Reset asserted mid-count takes effect at the next edge and discards any concurrent load, limit write or step.

## Test plan

- Reset then up count (WIDTH=10, STEP=1, SATURATE=0): hold reset 2 cycles, then cnt_en=1, up_dn=1 -> count_out = 0, 1, 2, … with tc = 0 and wrap_flag = 0 throughout.
- Wrap up: limit_wr with limit_in=0x005, count from 0 -> 1..5, then 0 with tc = 1 for one cycle and wrap_flag = 1; clr_flags -> wrap_flag = 0 the next cycle.
- Wrap down with step (STEP=3, limit=0x3FF): load 0x004, then count down -> 0x001, then 0x3FF with tc pulse.
- Saturate (SATURATE=1, limit=0x010):
  - Load 0x00E and count up -> 0x010 (boundary event, tc = 1), then 0x010 again with tc = 1.
  - Down count from 0x000 -> stays 0x000 with tc = 1.
- Simultaneous events:
  - load_en, cnt_en and limit_wr together -> count_out = data_in, limit updated, tc = 0.
  - clr_flags on a wrap cycle -> wrap_flag = 1.
- Reset mid-operation: reset while counting at 0x1A3 with load_en=1 -> count_out = RESET_VAL, limit = 0x3FF, flags = 0 on the next cycle.
